dvi_tmds_encoder: RTL and testbench



---
 rtl/dvi_tmds_encoder.sv | 219 +++++++++++++++++++++
 tb/tb_dvi_tmds_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: 12-bit RGB + syncs + DE -> three 10-bit symbols, fixed 3-clock latency, no backpressure.
// Optional build macro DVI_ENC_SCANLINES_EN dims odd active lines to 50% (line parity cleared by vsync).
module dvi_tmds_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_r,
  input  logic [3:0] in_g,
  input  logic [3:0] in_b,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcnt8(input logic [7:0] d);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, d[i]};
    end
    return ones;
  endfunction

  // Transition minimisation; q_m[8] = 1 flags XOR mode.
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones     = popcnt8(d);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  // DC balance: returns {symbol[9:0], next running disparity[4:0]}.
  function automatic logic [14:0] balance(input logic [8:0] q_m,
                                          input logic [3:0] n1,
                                          input logic [3:0] n0,
                                          input logic [4:0] cnt);
    logic [4:0] n1x;
    logic [4:0] n0x;
    logic [4:0] nxt;
    logic [9:0] sym;
    logic       cnt_zero;
    logic       cnt_neg;
    logic       cnt_pos;
    n1x      = {1'b0, n1};
    n0x      = {1'b0, n0};
    cnt_zero = (cnt == 5'd0);
    cnt_neg  = cnt[4];
    cnt_pos  = !cnt_neg && !cnt_zero;
    if (cnt_zero || (n1 == n0)) begin
      sym = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      nxt = q_m[8] ? (cnt + n1x - n0x) : (cnt + n0x - n1x);
    end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
      sym = {1'b1, q_m[8], ~q_m[7:0]};
      nxt = cnt + {3'b000, q_m[8], 1'b0} + n0x - n1x;
    end else begin
      sym = {1'b0, q_m[8], q_m[7:0]};
      nxt = cnt + n1x - n0x - {3'b000, ~q_m[8], 1'b0};
    end
    return {sym, nxt};
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    logic [9:0] sym;
    case ({c1, c0})
      2'b00:   sym = CTRL_00;
      2'b01:   sym = CTRL_01;
      2'b10:   sym = CTRL_10;
      default: sym = CTRL_11;
    endcase
    return sym;
  endfunction

  // Stage 1: input register with 4->8 bit replication
  logic [7:0] s1_r, s1_g, s1_b;
  logic       s1_de, s1_hsync, s1_vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r     <= 8'd0;
      s1_g     <= 8'd0;
      s1_b     <= 8'd0;
      s1_de    <= 1'b0;
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
    end else begin
      s1_r     <= {in_r, in_r};
      s1_g     <= {in_g, in_g};
      s1_b     <= {in_b, in_b};
      s1_de    <= in_de;
      s1_hsync <= in_hsync;
      s1_vsync <= in_vsync;
    end
  end

  logic [7:0] s1_r_eff, s1_g_eff, s1_b_eff;

`ifdef DVI_ENC_SCANLINES_EN
  logic s1_de_d;
  logic line_odd;

  // Parity flips at the end of each active line; vsync re-aligns it to even.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_de_d  <= 1'b0;
      line_odd <= 1'b0;
    end else begin
      s1_de_d <= s1_de;
      if (s1_vsync) begin
        line_odd <= 1'b0;
      end else if (s1_de_d && !s1_de) begin
        line_odd <= ~line_odd;
      end
    end
  end

  assign s1_r_eff = line_odd ? {1'b0, s1_r[7:1]} : s1_r;
  assign s1_g_eff = line_odd ? {1'b0, s1_g[7:1]} : s1_g;
  assign s1_b_eff = line_odd ? {1'b0, s1_b[7:1]} : s1_b;
`else
  assign s1_r_eff = s1_r;
  assign s1_g_eff = s1_g;
  assign s1_b_eff = s1_b;
`endif

  // Stage 2: transition minimisation and ones/zeros count of q_m[7:0]
  logic [8:0] qm_r_nxt, qm_g_nxt, qm_b_nxt;

  always_comb begin
    qm_r_nxt = minimise(s1_r_eff);
    qm_g_nxt = minimise(s1_g_eff);
    qm_b_nxt = minimise(s1_b_eff);
  end

  logic [8:0] s2_qm_r, s2_qm_g, s2_qm_b;
  logic [3:0] s2_n1_r, s2_n1_g, s2_n1_b;
  logic [3:0] s2_n0_r, s2_n0_g, s2_n0_b;
  logic       s2_de, s2_hsync, s2_vsync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_qm_r  <= 9'd0;
      s2_qm_g  <= 9'd0;
      s2_qm_b  <= 9'd0;
      s2_n1_r  <= 4'd0;
      s2_n1_g  <= 4'd0;
      s2_n1_b  <= 4'd0;
      s2_n0_r  <= 4'd0;
      s2_n0_g  <= 4'd0;
      s2_n0_b  <= 4'd0;
      s2_de    <= 1'b0;
      s2_hsync <= 1'b0;
      s2_vsync <= 1'b0;
    end else begin
      s2_qm_r  <= qm_r_nxt;
      s2_qm_g  <= qm_g_nxt;
      s2_qm_b  <= qm_b_nxt;
      s2_n1_r  <= popcnt8(qm_r_nxt[7:0]);
      s2_n1_g  <= popcnt8(qm_g_nxt[7:0]);
      s2_n1_b  <= popcnt8(qm_b_nxt[7:0]);
      s2_n0_r  <= 4'd8 - popcnt8(qm_r_nxt[7:0]);
      s2_n0_g  <= 4'd8 - popcnt8(qm_g_nxt[7:0]);
      s2_n0_b  <= 4'd8 - popcnt8(qm_b_nxt[7:0]);
      s2_de    <= s1_de;
      s2_hsync <= s1_hsync;
      s2_vsync <= s1_vsync;
    end
  end

  // Stage 3: DC balance; symbols leave straight from these flops
  logic [4:0]  cnt_r, cnt_g, cnt_b;
  logic [14:0] bal_r, bal_g, bal_b;

  always_comb begin
    bal_r = balance(s2_qm_r, s2_n1_r, s2_n0_r, cnt_r);
    bal_g = balance(s2_qm_g, s2_n1_g, s2_n0_g, cnt_g);
    bal_b = balance(s2_qm_b, s2_n1_b, s2_n0_b, cnt_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmds_ch0 <= CTRL_00;
      tmds_ch1 <= CTRL_00;
      tmds_ch2 <= CTRL_00;
      cnt_r    <= 5'd0;
      cnt_g    <= 5'd0;
      cnt_b    <= 5'd0;
    end else if (!s2_de) begin
      tmds_ch0 <= ctrl_sym(s2_vsync, s2_hsync);
      tmds_ch1 <= CTRL_00;
      tmds_ch2 <= CTRL_00;
      cnt_r    <= 5'd0;
      cnt_g    <= 5'd0;
      cnt_b    <= 5'd0;
    end else begin
      tmds_ch0 <= bal_b[14:5];
      tmds_ch1 <= bal_g[14:5];
      tmds_ch2 <= bal_r[14:5];
      cnt_b    <= bal_b[4:0];
      cnt_g    <= bal_g[4:0];
      cnt_r    <= bal_r[4:0];
    end
  end

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder: directed vectors with hand-computed symbols, 3-clock latency.
module tb_dvi_tmds_encoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic       clk;
  logic       reset;
  logic [3:0] in_r, in_g, in_b;
  logic       in_hsync, in_vsync, in_de;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;

  dvi_tmds_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .in_hsync (in_hsync),
    .in_vsync (in_vsync),
    .in_de    (in_de),
    .tmds_ch0 (tmds_ch0),
    .tmds_ch1 (tmds_ch1),
    .tmds_ch2 (tmds_ch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Monitor: compares the symbols due on this cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s: expectation due at cycle %0d not compared (now %0d)", e.nm, e.due, cyc);
        end else begin
          check({e.nm, " ch0"}, tmds_ch0, e.e0);
          check({e.nm, " ch1"}, tmds_ch1, e.e1);
          check({e.nm, " ch2"}, tmds_ch2, e.e2);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic hs, input logic vs, input logic de,
                       input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                       input string nm);
    exp_t e;
    @(negedge clk);
    in_r = r; in_g = g; in_b = b;
    in_hsync = hs; in_vsync = vs; in_de = de;
    e.due = cyc + 3; e.e0 = e0; e.e1 = e1; e.e2 = e2; e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic ctrl(input logic hs, input logic vs, input logic [9:0] e0, input string nm);
    drive(4'h0, 4'h0, 4'h0, hs, vs, 1'b0, e0, C00, C00, nm);
  endtask

  task automatic pix(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                     input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                     input string nm);
    drive(r, g, b, 1'b0, 1'b0, 1'b1, e0, e1, e2, nm);
  endtask

  localparam logic [9:0] BLK_A = 10'b0100000000;
  localparam logic [9:0] BLK_B = 10'b1111111111;
  localparam logic [9:0] FF_A  = 10'b1000000000;
  localparam logic [9:0] FF_B  = 10'b0011111111;
  localparam logic [9:0] D88   = 10'b0101111000;
  localparam logic [9:0] D44   = 10'b0100111100;
`ifdef DVI_ENC_SCANLINES_EN
  localparam logic [9:0] LINE1 = D44;
`else
  localparam logic [9:0] LINE1 = D88;
`endif

  initial begin
    reset = 1'b1;
    in_r = 4'h0; in_g = 4'h0; in_b = 4'h0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
    #2;
    check("reset state ch0", tmds_ch0, C00);
    check("reset state ch1", tmds_ch1, C00);
    check("reset state ch2", tmds_ch2, C00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) ctrl(1'b0, 1'b0, C00, "idle after reset");

    // Control codes on ch0 follow {vsync, hsync}
    ctrl(1'b1, 1'b0, C01, "ctrl hs");
    ctrl(1'b1, 1'b0, C01, "ctrl hs hold");
    ctrl(1'b1, 1'b1, C11, "ctrl hs vs");
    ctrl(1'b0, 1'b1, C10, "ctrl vs");
    ctrl(1'b0, 1'b0, C00, "ctrl none");

    // Running disparity on black: -8, +2, -6
    ctrl(1'b0, 1'b1, C10, "pre black vs");
    ctrl(1'b0, 1'b0, C00, "pre black");
    pix(4'h0, 4'h0, 4'h0, BLK_A, BLK_A, BLK_A, "black 1");
    pix(4'h0, 4'h0, 4'h0, BLK_B, BLK_B, BLK_B, "black 2");
    pix(4'h0, 4'h0, 4'h0, BLK_A, BLK_A, BLK_A, "black 3");
    ctrl(1'b0, 1'b0, C00, "black gap");
    pix(4'h0, 4'h0, 4'h0, BLK_A, BLK_A, BLK_A, "black after clear");
    ctrl(1'b0, 1'b0, C00, "post black");

    // Full scale: XNOR mode, cnt -8, -2, +4, -4
    ctrl(1'b0, 1'b1, C10, "pre fff vs");
    ctrl(1'b0, 1'b0, C00, "pre fff");
    pix(4'hF, 4'hF, 4'hF, FF_A, FF_A, FF_A, "fff 1");
    pix(4'hF, 4'hF, 4'hF, FF_B, FF_B, FF_B, "fff 2");
    pix(4'hF, 4'hF, 4'hF, FF_B, FF_B, FF_B, "fff 3");
    pix(4'hF, 4'hF, 4'hF, FF_A, FF_A, FF_A, "fff 4");
    ctrl(1'b0, 1'b0, C00, "post fff");

    // Mixed pixel R=1 G=3 B=A; hsync is ignored while DE is high
    ctrl(1'b0, 1'b1, C10, "pre mix vs");
    ctrl(1'b0, 1'b0, C00, "pre mix");
    pix(4'h1, 4'h3, 4'hA, 10'b1000110011, 10'b0100010001, 10'b0100001111, "mix 1");
    drive(4'h1, 4'h3, 4'hA, 1'b1, 1'b0, 1'b1,
          10'b1000110011, 10'b1111101110, 10'b0100001111, "mix 2");
    ctrl(1'b0, 1'b0, C00, "post mix");

    // Scanline parity across lines of 888, vsync realigns
    ctrl(1'b0, 1'b1, C10, "pre scan vs");
    ctrl(1'b0, 1'b0, C00, "pre scan");
    pix(4'h8, 4'h8, 4'h8, D88, D88, D88, "line 0");
    ctrl(1'b0, 1'b0, C00, "gap 0a");
    ctrl(1'b0, 1'b0, C00, "gap 0b");
    pix(4'h8, 4'h8, 4'h8, LINE1, LINE1, LINE1, "line 1");
    ctrl(1'b0, 1'b0, C00, "gap 1a");
    ctrl(1'b0, 1'b0, C00, "gap 1b");
    pix(4'h8, 4'h8, 4'h8, D88, D88, D88, "line 2");
    ctrl(1'b0, 1'b0, C00, "gap 2a");
    ctrl(1'b0, 1'b1, C10, "gap 2 vs");
    ctrl(1'b0, 1'b0, C00, "gap 2b");
    pix(4'h8, 4'h8, 4'h8, D88, D88, D88, "line after vsync");
    ctrl(1'b0, 1'b0, C00, "post scan");

    // Asynchronous reset mid-stream discards in-flight pixels
    ctrl(1'b0, 1'b1, C10, "pre reset vs");
    ctrl(1'b0, 1'b0, C00, "pre reset");
    pix(4'hF, 4'hF, 4'hF, FF_A, FF_A, FF_A, "rst fff 1");
    pix(4'hF, 4'hF, 4'hF, FF_B, FF_B, FF_B, "rst fff 2");
    pix(4'hF, 4'hF, 4'hF, FF_B, FF_B, FF_B, "rst fff 3");
    pix(4'hF, 4'hF, 4'hF, FF_A, FF_A, FF_A, "rst fff 4");
    @(negedge clk);
    #2;
    reset = 1'b1;
    in_r = 4'h0; in_g = 4'h0; in_b = 4'h0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;
    sb_q.delete();
    #1;
    check("async reset ch0", tmds_ch0, C00);
    check("async reset ch1", tmds_ch1, C00);
    check("async reset ch2", tmds_ch2, C00);
    @(negedge clk);
    check("held reset ch0", tmds_ch0, C00);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) ctrl(1'b0, 1'b0, C00, "idle after release");
    pix(4'h0, 4'h0, 4'h0, BLK_A, BLK_A, BLK_A, "black after reset");
    ctrl(1'b0, 1'b0, C00, "tail");

    begin
      int waited;
      waited = 0;
      while (sb_q.size() > 0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (sb_q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
